thermal_power_governor: RTL and testbench



---
 rtl/thermal_power_governor_if.sv | 44 ++++
 rtl/thermal_power_governor.sv | 247 ++++++++++++++++++++++++
 tb/tb_thermal_power_governor.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thermal_power_governor_if.sv
// Signal bundle between the governor and its sensors and actuators.
// master: the environment (sensors, power monitor, battery, policy inputs).
// slave: the governor (DVFS levels, gating, emergency flags, telemetry).
interface thermal_power_governor_if #(
    parameter int unsigned NUM_DOMAINS = 8,
    parameter int unsigned TEMP_W      = 16,
    parameter int unsigned LVL_W       = 8
);
    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic [NUM_DOMAINS*TEMP_W-1:0] temperature;
    logic [TEMP_W-1:0]             temp_warn;
    logic [TEMP_W-1:0]             temp_crit;
    logic [31:0]                   power_budget;
    logic [31:0]                   power_measured;
    logic                          ac_power_available;
    logic [7:0]                    battery_level;
    logic [7:0]                    battery_low_thresh;
    logic [NUM_DOMAINS-1:0]        domain_essential;

    logic [NUM_DOMAINS*LVL_W-1:0]  level;
    logic [NUM_DOMAINS*2-1:0]      domain_state;
    logic [NUM_DOMAINS-1:0]        domain_power_enable;
    logic [NUM_DOMAINS-1:0]        domain_clock_enable;
    logic                          thermal_emergency;
    logic                          power_emergency;
    logic [15:0]                   emergency_count;
    logic [TEMP_W-1:0]             max_temp;
    logic [IDX_W-1:0]              hottest_domain;

    modport master (
        output temperature, temp_warn, temp_crit, power_budget, power_measured,
               ac_power_available, battery_level, battery_low_thresh, domain_essential,
        input  level, domain_state, domain_power_enable, domain_clock_enable,
               thermal_emergency, power_emergency, emergency_count, max_temp, hottest_domain
    );

    modport slave (
        input  temperature, temp_warn, temp_crit, power_budget, power_measured,
               ac_power_available, battery_level, battery_low_thresh, domain_essential,
        output level, domain_state, domain_power_enable, domain_clock_enable,
               thermal_emergency, power_emergency, emergency_count, max_temp, hottest_domain
    );
endinterface

// File: rtl/thermal_power_governor.sv
// Per-domain thermal/power governor: debounced thermal FSM with hysteresis per domain,
// stepped DVFS level, global power-budget cap, battery cap and essential-domain gating.
// Optional max-temperature telemetry is built only when THERMAL_TELEMETRY_EN is defined;
// otherwise max_temp and hottest_domain are tied to 0.
module thermal_power_governor #(
    parameter int unsigned       NUM_DOMAINS   = 8,
    parameter int unsigned       TEMP_W        = 16,
    parameter int unsigned       LVL_W         = 8,
    parameter int unsigned       DEBOUNCE      = 4,
    parameter int unsigned       STEP_INTERVAL = 16,
    parameter logic [TEMP_W-1:0] HYST          = 16'h0400,
    parameter logic [LVL_W-1:0]  LVL_MAX       = 8'hC0,
    parameter logic [LVL_W-1:0]  LVL_BAT_MAX   = 8'h80,
    parameter logic [LVL_W-1:0]  LVL_MIN       = 8'h40,
    parameter logic [LVL_W-1:0]  LVL_STEP      = 8'h10
) (
    input logic                     clk,
    input logic                     rst,
    thermal_power_governor_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned TMR_W = $clog2(STEP_INTERVAL);
    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [1:0] {
        StNormal    = 2'd0,
        StThrottle  = 2'd1,
        StEmergency = 2'd2,
        StCooldown  = 2'd3
    } state_e;

    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   tick;
    logic [LVL_W-1:0]       budget_cap_q, budget_cap_d;
    logic [LVL_W-1:0]       base_cap, cap;
    logic [LVL_W:0]         bc_up, bc_dn;
    logic [TEMP_W-1:0]      cool_thr;
    logic                   power_emergency_q, power_emergency_d;
    logic                   thermal_emergency_q, thermal_emergency_d;
    logic [15:0]            emergency_count_q, emergency_count_d;
    logic [16:0]            count_sum;
    logic [NUM_DOMAINS-1:0] enter_vec, in_emerg, clk_en_vec, pwr_en;
    logic [LVL_W-1:0]       level_arr [NUM_DOMAINS];
    logic [1:0]             state_arr [NUM_DOMAINS];

    assign tick     = (timer_q == TMR_W'(STEP_INTERVAL - 1));
    assign base_cap = bus.ac_power_available ? LVL_MAX : LVL_BAT_MAX;
    assign cap      = (budget_cap_q < base_cap) ? budget_cap_q : base_cap;
    // Cool-down threshold clamps at zero instead of wrapping.
    assign cool_thr = (bus.temp_warn > HYST) ? (bus.temp_warn - HYST) : '0;
    assign pwr_en   = bus.domain_essential | {NUM_DOMAINS{~power_emergency_q}};

    // Step timer, budget cap, emergency flags and entry counter next-state.
    always_comb begin
        timer_d      = tick ? '0 : timer_q + 1'b1;
        budget_cap_d = budget_cap_q;
        bc_up        = {1'b0, budget_cap_q} + {1'b0, LVL_STEP};
        bc_dn        = {1'b0, budget_cap_q} - {1'b0, LVL_STEP};
        if (tick) begin
            if (bus.power_measured > bus.power_budget) begin
                budget_cap_d = (bc_dn[LVL_W] || (bc_dn[LVL_W-1:0] < LVL_MIN))
                             ? LVL_MIN : bc_dn[LVL_W-1:0];
            end else begin
                budget_cap_d = (bc_up > {1'b0, LVL_MAX}) ? LVL_MAX : bc_up[LVL_W-1:0];
            end
        end
        power_emergency_d   = ~bus.ac_power_available &&
                              (bus.battery_level < bus.battery_low_thresh);
        thermal_emergency_d = |in_emerg;
        count_sum           = {1'b0, emergency_count_q};
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            count_sum = count_sum + 17'(enter_vec[i]);
        end
        emergency_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // Global state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q             <= '0;
            budget_cap_q        <= LVL_MAX;
            power_emergency_q   <= 1'b0;
            thermal_emergency_q <= 1'b0;
            emergency_count_q   <= '0;
        end else begin
            timer_q             <= timer_d;
            budget_cap_q        <= budget_cap_d;
            power_emergency_q   <= power_emergency_d;
            thermal_emergency_q <= thermal_emergency_d;
            emergency_count_q   <= emergency_count_d;
        end
    end

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        logic [TEMP_W-1:0] temp;
        state_e            state_q, state_d;
        logic [LVL_W-1:0]  level_q, level_d;
        logic              clk_en_q, clk_en_d;
        logic [CNT_W-1:0]  hot_cnt_q, hot_cnt_d, crit_cnt_q, crit_cnt_d, cool_cnt_q, cool_cnt_d;
        logic              hot_ok, crit_ok, cool_ok, enter;
        logic [LVL_W:0]    up_w, dn_w;
        logic [LVL_W-1:0]  up_sat, dn_sat;

        assign temp    = bus.temperature[g*TEMP_W +: TEMP_W];
        assign hot_ok  = (hot_cnt_q == CNT_W'(DEBOUNCE));
        assign crit_ok = (crit_cnt_q == CNT_W'(DEBOUNCE));
        assign cool_ok = (cool_cnt_q == CNT_W'(DEBOUNCE));

        // Debounce counters: saturate at DEBOUNCE, clear on any non-qualifying sample.
        always_comb begin
            hot_cnt_d  = '0;
            crit_cnt_d = '0;
            cool_cnt_d = '0;
            if (temp > bus.temp_warn) begin
                hot_cnt_d = hot_ok ? hot_cnt_q : hot_cnt_q + 1'b1;
            end
            if (temp > bus.temp_crit) begin
                crit_cnt_d = crit_ok ? crit_cnt_q : crit_cnt_q + 1'b1;
            end
            if (temp <= cool_thr) begin
                cool_cnt_d = cool_ok ? cool_cnt_q : cool_cnt_q + 1'b1;
            end
        end

        // Thermal FSM and DVFS level next-state; level math is one bit wider, then saturated.
        always_comb begin
            state_d  = state_q;
            level_d  = level_q;
            clk_en_d = clk_en_q;
            enter    = 1'b0;
            up_w     = {1'b0, level_q} + {1'b0, LVL_STEP};
            dn_w     = {1'b0, level_q} - {1'b0, LVL_STEP};
            up_sat   = (up_w > {1'b0, cap}) ? cap : up_w[LVL_W-1:0];
            dn_sat   = (dn_w[LVL_W] || (dn_w[LVL_W-1:0] < LVL_MIN)) ? LVL_MIN : dn_w[LVL_W-1:0];
            unique case (state_q)
                StNormal: begin
                    level_d = (level_q > cap) ? cap : (tick ? up_sat : level_q);
                    if (crit_ok)     state_d = StEmergency;
                    else if (hot_ok) state_d = StThrottle;
                end
                StThrottle: begin
                    level_d = tick ? dn_sat : level_q;
                    if (level_d > cap) level_d = cap;
                    if (crit_ok)      state_d = StEmergency;
                    else if (cool_ok) state_d = StCooldown;
                end
                StEmergency: begin
                    level_d = LVL_MIN;
                    if (cool_ok) begin
                        state_d  = StCooldown;
                        clk_en_d = 1'b1;
                    end
                end
                StCooldown: begin
                    level_d = (level_q > cap) ? cap : (tick ? up_sat : level_q);
                    if (crit_ok)               state_d = StEmergency;
                    else if (hot_ok)           state_d = StThrottle;
                    else if (level_q == cap)   state_d = StNormal;
                end
                default: ;
            endcase
            // Entry into EMERGENCY overrides the level rule of the state being left.
            if ((state_d == StEmergency) && (state_q != StEmergency)) begin
                level_d  = LVL_MIN;
                clk_en_d = 1'b0;
                enter    = 1'b1;
            end
        end

        // Per-domain state registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= StNormal;
                level_q    <= LVL_MAX;
                clk_en_q   <= 1'b1;
                hot_cnt_q  <= '0;
                crit_cnt_q <= '0;
                cool_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                level_q    <= level_d;
                clk_en_q   <= clk_en_d;
                hot_cnt_q  <= hot_cnt_d;
                crit_cnt_q <= crit_cnt_d;
                cool_cnt_q <= cool_cnt_d;
            end
        end

        assign level_arr[g]  = level_q;
        assign state_arr[g]  = state_q;
        assign enter_vec[g]  = enter;
        assign in_emerg[g]   = (state_q == StEmergency);
        assign clk_en_vec[g] = clk_en_q;
    end

    // Pack per-domain results onto the bus.
    always_comb begin
        bus.level        = '0;
        bus.domain_state = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            bus.level[i*LVL_W +: LVL_W] = level_arr[i];
            bus.domain_state[i*2 +: 2]  = state_arr[i];
        end
    end

    // A gated domain never gets a clock even if its FSM would allow one.
    assign bus.domain_power_enable = pwr_en;
    assign bus.domain_clock_enable = clk_en_vec & pwr_en;
    assign bus.thermal_emergency   = thermal_emergency_q;
    assign bus.power_emergency     = power_emergency_q;
    assign bus.emergency_count     = emergency_count_q;

`ifdef THERMAL_TELEMETRY_EN
    logic [TEMP_W-1:0] max_temp_q, max_temp_d;
    logic [IDX_W-1:0]  hottest_q, hottest_d;

    // Max-temperature scan; strict compare keeps the lowest index on ties.
    always_comb begin
        max_temp_d = bus.temperature[0 +: TEMP_W];
        hottest_d  = '0;
        for (int i = 1; i < NUM_DOMAINS; i++) begin
            if (bus.temperature[i*TEMP_W +: TEMP_W] > max_temp_d) begin
                max_temp_d = bus.temperature[i*TEMP_W +: TEMP_W];
                hottest_d  = IDX_W'(i);
            end
        end
    end

    // Telemetry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_temp_q <= '0;
            hottest_q  <= '0;
        end else begin
            max_temp_q <= max_temp_d;
            hottest_q  <= hottest_d;
        end
    end

    assign bus.max_temp       = max_temp_q;
    assign bus.hottest_domain = hottest_q;
`else
    assign bus.max_temp       = '0;
    assign bus.hottest_domain = '0;
`endif

endmodule

// File: tb/tb_thermal_power_governor.sv
// Self-checking bench for thermal_power_governor: expected values are queued when stimulus
// is applied and popped when the DUT output is sampled (on the falling clock edge).
module tb_thermal_power_governor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    thermal_power_governor_if #(.NUM_DOMAINS(8), .TEMP_W(16), .LVL_W(8)) bus ();

    thermal_power_governor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [63:0] LV_C0 = 64'hC0C0_C0C0_C0C0_C0C0;
    localparam logic [63:0] LV_B0 = 64'hB0B0_B0B0_B0B0_B0B0;
    localparam logic [63:0] LV_80 = 64'h8080_8080_8080_8080;
    localparam logic [63:0] LV_40 = 64'h4040_4040_4040_4040;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_temp(input int d, input logic [15:0] t);
        bus.temperature[d*16 +: 16] = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.temperature        = {8{16'h3000}};
        bus.temp_warn          = 16'h5000;
        bus.temp_crit          = 16'h5800;
        bus.power_budget       = 32'd150;
        bus.power_measured     = 32'd100;
        bus.ac_power_available = 1'b1;
        bus.battery_level      = 8'd100;
        bus.battery_low_thresh = 8'd15;
        bus.domain_essential   = 8'h01;
        cycles(3);
        sb.push_back(LV_C0);
        sb.push_back(64'h0);
        sb.push_back(64'hFFFF);
        sb.push_back(64'h0);
        sb.push_back(64'h0);
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL rst_level: got %h want %h", bus.level, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL rst_state: got %h want %h", bus.domain_state, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.domain_power_enable, bus.domain_clock_enable}) !== exp_v) begin
            n_fail++; $display("FAIL rst_enables: got %h%h want %h",
                               bus.domain_power_enable, bus.domain_clock_enable, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.thermal_emergency, bus.power_emergency, bus.emergency_count}) !== exp_v)
        begin
            n_fail++; $display("FAIL rst_flags: te %b pe %b cnt %h want all zero",
                               bus.thermal_emergency, bus.power_emergency, bus.emergency_count);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.max_temp, bus.hottest_domain}) !== exp_v) begin
            n_fail++; $display("FAIL rst_telemetry: got %h/%0d want 0",
                               bus.max_temp, bus.hottest_domain);
        end
        rst = 1'b0;
        sb.push_back(LV_C0);
        sb.push_back(64'h0);
        sb.push_back({48'h0, 16'hFFFF, 2'b00});
        cycles(100);
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL idle_level: got %h want %h", bus.level, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL idle_state: got %h want %h", bus.domain_state, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.domain_power_enable, bus.domain_clock_enable,
                 bus.thermal_emergency, bus.power_emergency}) !== exp_v) begin
            n_fail++; $display("FAIL idle_enables_flags: got %h %h %b %b want %h",
                               bus.domain_power_enable, bus.domain_clock_enable,
                               bus.thermal_emergency, bus.power_emergency, exp_v);
        end
    endtask

    task automatic test_glitch();
        set_temp(2, 16'h5C00);
        cycles(3);
        set_temp(2, 16'h3000);
        sb.push_back(64'h0);
        sb.push_back(64'h0);
        cycles(10);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL glitch_state: got %h want %h", bus.domain_state, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.emergency_count, bus.thermal_emergency}) !== exp_v) begin
            n_fail++; $display("FAIL glitch_count: cnt %h te %b want 0",
                               bus.emergency_count, bus.thermal_emergency);
        end
    endtask

    task automatic test_throttle();
        int n;
        set_temp(2, 16'h5200);
        sb.push_back(64'h0);
        cycles(4);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL thr_debounce_early: got %h want %h", bus.domain_state, exp_v);
        end
        sb.push_back(64'h0010);
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL thr_enter: got %h want %h", bus.domain_state, exp_v);
        end
        sb.push_back(64'hC0C0_C0C0_C0B0_C0C0);
        n = 0;
        while (bus.level[23:16] == 8'hC0 && n < 20) begin cycles(1); n++; end
        n_assert++;
        if (n >= 20) begin n_fail++; $display("FAIL thr_step_timeout: waited %0d limit 20", n); end
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL thr_first_step: got %h want %h", bus.level, exp_v);
        end
        sb.push_back(64'hC0C0_C0C0_C040_C0C0);
        n = 0;
        while (bus.level[23:16] != 8'h40 && n < 150) begin cycles(1); n++; end
        cycles(40);
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL thr_floor: got %h want %h", bus.level, exp_v);
        end
        // Between warn-HYST and warn: neither hot nor cool qualifies.
        set_temp(2, 16'h4E00);
        sb.push_back(64'h0010);
        cycles(40);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL thr_hysteresis: got %h want %h", bus.domain_state, exp_v);
        end
        set_temp(2, 16'h3000);
        sb.push_back(64'h0030);
        cycles(5);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL thr_cooldown: got %h want %h", bus.domain_state, exp_v);
        end
        sb.push_back(LV_C0);
        n = 0;
        while (bus.domain_state != 16'h0 && n < 200) begin cycles(1); n++; end
        n_assert++;
        if (n >= 200) begin n_fail++; $display("FAIL thr_normal_timeout: waited %0d limit 200", n); end
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL thr_recovered_level: got %h want %h", bus.level, exp_v);
        end
    endtask

    task automatic test_emergency();
        int n;
        set_temp(2, 16'h5C00);
        sb.push_back(64'h0);
        cycles(4);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL emg_debounce_early: got %h want %h", bus.domain_state, exp_v);
        end
        sb.push_back(64'h0020);
        sb.push_back(64'hC0C0_C0C0_C040_C0C0);
        sb.push_back({32'h0, 8'hFB, 1'b0, 7'h0, 16'h0001});
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL emg_enter: got %h want %h", bus.domain_state, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL emg_level: got %h want %h", bus.level, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if ({32'h0, bus.domain_clock_enable, bus.thermal_emergency, 7'h0, bus.emergency_count}
            !== exp_v) begin
            n_fail++; $display("FAIL emg_clk_te_cnt: clk %h te %b cnt %h want %h",
                               bus.domain_clock_enable, bus.thermal_emergency,
                               bus.emergency_count, exp_v);
        end
        sb.push_back(64'h1);
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.thermal_emergency) !== exp_v) begin
            n_fail++; $display("FAIL emg_flag: got %b want 1", bus.thermal_emergency);
        end
        set_temp(2, 16'h4000);
        sb.push_back({48'h0, 8'hFF, 8'h30});
        cycles(5);
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.domain_clock_enable, bus.domain_state[7:0]}) !== exp_v) begin
            n_fail++; $display("FAIL emg_cooldown: clk %h state %h want %h",
                               bus.domain_clock_enable, bus.domain_state, exp_v);
        end
        sb.push_back(LV_C0);
        sb.push_back({47'h0, 1'b0, 16'h0001});
        n = 0;
        while (bus.domain_state != 16'h0 && n < 200) begin cycles(1); n++; end
        n_assert++;
        if (n >= 200) begin n_fail++; $display("FAIL emg_normal_timeout: waited %0d limit 200", n); end
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL emg_recovered_level: got %h want %h", bus.level, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.thermal_emergency, bus.emergency_count}) !== exp_v) begin
            n_fail++; $display("FAIL emg_final: te %b cnt %h want %h",
                               bus.thermal_emergency, bus.emergency_count, exp_v);
        end
    endtask

    task automatic test_battery();
        int n;
        bus.ac_power_available = 1'b0;
        bus.battery_level      = 8'd50;
        sb.push_back({LV_80[62:0], 1'b0});
        sb.push_back(64'hFFFF);
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if ({bus.level[62:0], bus.power_emergency} !== exp_v) begin
            n_fail++; $display("FAIL bat_cap: level %h pe %b want %h/0",
                               bus.level, bus.power_emergency, LV_80);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.domain_power_enable, bus.domain_clock_enable}) !== exp_v) begin
            n_fail++; $display("FAIL bat_no_gate: got %h %h want %h",
                               bus.domain_power_enable, bus.domain_clock_enable, exp_v);
        end
        bus.battery_level = 8'd10;
        sb.push_back({47'h0, 1'b1, 8'h01, 8'h01});
        sb.push_back(LV_80);
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.power_emergency, bus.domain_power_enable, bus.domain_clock_enable})
            !== exp_v) begin
            n_fail++; $display("FAIL bat_gate: pe %b pwr %h clk %h want %h", bus.power_emergency,
                               bus.domain_power_enable, bus.domain_clock_enable, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL bat_gate_level: got %h want %h", bus.level, exp_v);
        end
        bus.ac_power_available = 1'b1;
        sb.push_back({47'h0, 1'b0, 8'hFF, 8'hFF});
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.power_emergency, bus.domain_power_enable, bus.domain_clock_enable})
            !== exp_v) begin
            n_fail++; $display("FAIL bat_restore: pe %b pwr %h clk %h want %h", bus.power_emergency,
                               bus.domain_power_enable, bus.domain_clock_enable, exp_v);
        end
        bus.battery_level = 8'd100;
        sb.push_back(LV_C0);
        n = 0;
        while (bus.level != LV_C0 && n < 120) begin cycles(1); n++; end
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL bat_climb: got %h want %h after %0d cycles", bus.level, exp_v, n);
        end
    endtask

    task automatic test_budget();
        int n;
        bus.power_measured = 32'd200;
        sb.push_back(LV_B0);
        n = 0;
        while (bus.level == LV_C0 && n < 20) begin cycles(1); n++; end
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL bud_first_step: got %h want %h after %0d cycles",
                               bus.level, exp_v, n);
        end
        sb.push_back(LV_40);
        sb.push_back(64'h0);
        n = 0;
        while (bus.level != LV_40 && n < 150) begin cycles(1); n++; end
        cycles(40);
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL bud_floor: got %h want %h", bus.level, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL bud_state: got %h want %h", bus.domain_state, exp_v);
        end
        bus.power_measured = 32'd100;
        sb.push_back(LV_C0);
        n = 0;
        while (bus.level != LV_C0 && n < 250) begin cycles(1); n++; end
        cycles(40);
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL bud_recover: got %h want %h", bus.level, exp_v);
        end
    endtask

    task automatic test_telemetry();
        set_temp(5, 16'h4800);
        set_temp(7, 16'h4800);
`ifdef THERMAL_TELEMETRY_EN
        sb.push_back({45'h0, 16'h4800, 3'd5});
`else
        sb.push_back(64'h0);
`endif
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.max_temp, bus.hottest_domain}) !== exp_v) begin
            n_fail++; $display("FAIL tel_tie: got %h/%0d want %h", bus.max_temp,
                               bus.hottest_domain, exp_v);
        end
        set_temp(7, 16'h4900);
`ifdef THERMAL_TELEMETRY_EN
        sb.push_back({45'h0, 16'h4900, 3'd7});
`else
        sb.push_back(64'h0);
`endif
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (64'({bus.max_temp, bus.hottest_domain}) !== exp_v) begin
            n_fail++; $display("FAIL tel_max: got %h/%0d want %h", bus.max_temp,
                               bus.hottest_domain, exp_v);
        end
        bus.temperature = {8{16'h3000}};
    endtask

    task automatic test_reset_mid();
        set_temp(2, 16'h5C00);
        sb.push_back(64'h0020);
        cycles(5);
        exp_v = sb.pop_front(); n_assert++;
        if (64'(bus.domain_state) !== exp_v) begin
            n_fail++; $display("FAIL mid_pre_state: got %h want %h", bus.domain_state, exp_v);
        end
        rst = 1'b1;
        sb.push_back(LV_C0);
        sb.push_back({16'h0, 16'h0, 8'hFF, 7'h0, 1'b0, 16'h0000});
        cycles(1);
        exp_v = sb.pop_front(); n_assert++;
        if (bus.level !== exp_v) begin
            n_fail++; $display("FAIL mid_level: got %h want %h", bus.level, exp_v);
        end
        exp_v = sb.pop_front(); n_assert++;
        if ({16'h0, bus.domain_state, bus.domain_clock_enable, 7'h0, bus.thermal_emergency,
             bus.emergency_count} !== exp_v) begin
            n_fail++; $display("FAIL mid_regs: state %h clk %h te %b cnt %h want %h",
                               bus.domain_state, bus.domain_clock_enable,
                               bus.thermal_emergency, bus.emergency_count, exp_v);
        end
        rst = 1'b0;
        set_temp(2, 16'h3000);
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_throttle();
        test_emergency();
        test_battery();
        test_budget();
        test_telemetry();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
